// File: rtl/core_seq_pkg.sv
// Shared types and defaults for the five-stage control sequencer.
package core_seq_pkg;

    typedef enum logic [3:0] {
        StBoot    = 4'd0,
        StIdle    = 4'd1,
        StFetch   = 4'd2,
        StDecode  = 4'd3,
        StExec    = 4'd4,
        StMem     = 4'd5,
        StMemWait = 4'd6,
        StWb      = 4'd7,
        StHalt    = 4'd8,
        StErr     = 4'd9
    } state_e;

    localparam int unsigned StateWidth    = 4;
    localparam int unsigned DefBootCycles = 4;
    localparam int unsigned DefMemWaitMax = 16;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter with a terminal-count flag (count == Term).
module seq_timer #(
    parameter int unsigned Width = 4,
    parameter int unsigned Term  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             inc,
    output logic             at_term
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign at_term = (count_q == Width'(Term));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: one instruction at a time, one-cycle stage enable strobes,
// memory-handshake stalls with timeout, halt handling and a retired-instruction counter.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES  = DefBootCycles,
    parameter int unsigned MEM_WAIT_MAX = DefMemWaitMax
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic        i_halt,
    input  logic        i_memReq,
    input  logic        i_memReady,
    input  logic        i_PCSrc,
    output logic        o_enIF,
    output logic        o_enID,
    output logic        o_enEX,
    output logic        o_enMEM,
    output logic        o_enWB,
    output logic        o_pcWrite,
    output logic        o_pcSel,
    output logic [3:0]  o_state,
    output logic        o_halted,
    output logic        o_timeout,
    output logic [31:0] o_instrCount
);

    localparam int unsigned BootW = cnt_width(BOOT_CYCLES);
    localparam int unsigned WaitW = cnt_width(MEM_WAIT_MAX);

    state_e      state_q, state_d;
    logic        halt_pending_q, halt_pending_d;
    logic        pc_sel_q, pc_sel_d;
    logic [31:0] count_q;

    logic        boot_term, wait_term;
    logic        wait_load, wait_inc;

    logic        en_if_q, en_id_q, en_ex_q, en_mem_q, en_wb_q;
    logic        halted_q, timeout_q;

    seq_timer #(
        .Width (BootW),
        .Term  (BOOT_CYCLES - 1)
    ) u_boot_timer (
        .clk        (i_clk),
        .rst        (i_reset),
        .load       (1'b0),
        .load_value ({BootW{1'b0}}),
        .inc        (state_q == StBoot),
        .at_term    (boot_term)
    );

    seq_timer #(
        .Width (WaitW),
        .Term  (MEM_WAIT_MAX - 1)
    ) u_wait_timer (
        .clk        (i_clk),
        .rst        (i_reset),
        .load       (wait_load),
        .load_value ({WaitW{1'b0}}),
        .inc        (wait_inc),
        .at_term    (wait_term)
    );

    always_comb begin
        state_d        = state_q;
        halt_pending_d = halt_pending_q;
        pc_sel_d       = pc_sel_q;
        wait_load      = 1'b0;
        wait_inc       = 1'b0;
        case (state_q)
            StBoot: begin
                if (boot_term) begin
                    state_d = i_run ? StFetch : StIdle;
                end
            end
            StIdle: begin
                if (i_run) begin
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                halt_pending_d = i_halt;
                state_d        = StExec;
            end
            StExec: state_d = StMem;
            StMem: begin
                if (!i_memReq || i_memReady) begin
                    pc_sel_d = i_PCSrc;
                    state_d  = StWb;
                end else begin
                    wait_load = 1'b1;
                    state_d   = StMemWait;
                end
            end
            StMemWait: begin
                if (i_memReady) begin
                    pc_sel_d = i_PCSrc;
                    state_d  = StWb;
                end else if (wait_term) begin
                    state_d = StErr;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            StWb: begin
                // A pending halt wins over a dropped run request.
                if (halt_pending_q) begin
                    state_d = StHalt;
                end else begin
                    state_d = i_run ? StFetch : StIdle;
                end
            end
            StHalt: state_d = StHalt;
            StErr:  state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    // Outputs are registered alongside the state so they always reflect state_q.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= StBoot;
            halt_pending_q <= 1'b0;
            pc_sel_q       <= 1'b0;
            count_q        <= 32'd0;
            en_if_q        <= 1'b0;
            en_id_q        <= 1'b0;
            en_ex_q        <= 1'b0;
            en_mem_q       <= 1'b0;
            en_wb_q        <= 1'b0;
            halted_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            pc_sel_q       <= pc_sel_d;
            if (state_q == StWb) begin
                count_q <= count_q + 32'd1;
            end
            en_if_q   <= (state_d == StFetch);
            en_id_q   <= (state_d == StDecode);
            en_ex_q   <= (state_d == StExec);
            en_mem_q  <= (state_d == StMem) || (state_d == StMemWait);
            en_wb_q   <= (state_d == StWb);
            halted_q  <= (state_d == StHalt);
            timeout_q <= (state_d == StErr);
        end
    end

    assign o_enIF       = en_if_q;
    assign o_enID       = en_id_q;
    assign o_enEX       = en_ex_q;
    assign o_enMEM      = en_mem_q;
    assign o_enWB       = en_wb_q;
    assign o_pcWrite    = en_wb_q;
    assign o_pcSel      = pc_sel_q;
    assign o_state      = state_q;
    assign o_halted     = halted_q;
    assign o_timeout    = timeout_q;
    assign o_instrCount = count_q;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control sequencer for the five-stage datapath (fetch, decode, execute, memory, writeback).
- Runs one instruction at a time and issues one-cycle stage enables in order.
- Stalls on data-memory handshakes and latches the branch decision for the PC update.
- Counts retired instructions and handles halt requests and memory-timeout errors.
- Replaces phase-clock generation with enable strobes on a single clock.

Parameters:
BOOT_CYCLES, 4, cycles spent in BOOT after reset release before any fetch (≥1)
MEM_WAIT_MAX, 16, maximum MEM_WAIT cycles without i_memReady before ERR (≥1)

Ports:
i_clk  in  1  core clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_run  in  1  sequencing enable, level-sensitive
i_halt  in  1  halt request from decode; sampled only in DECODE
i_memReq  in  1  current instruction accesses data memory; sampled in MEM
i_memReady  in  1  data-memory ready/ack; sampled in MEM and MEM_WAIT
i_PCSrc  in  1  branch-taken from memory stage; sampled on MEM/MEM_WAIT exit
o_enIF  out  1  fetch enable
o_enID  out  1  decode/register-read enable
o_enEX  out  1  execute enable
o_enMEM  out  1  data-memory enable
o_enWB  out  1  register writeback enable
o_pcWrite  out  1  PC update strobe
o_pcSel  out  1  latched branch-taken (selects branch target when o_pcWrite=1)
o_state  out  4  current FSM state encoding
o_halted  out  1  in HALT
o_timeout  out  1  in ERR (memory timeout)
o_instrCount  out  32  retired-instruction counter

Behaviour:
- All outputs are registered or decoded from the state register only (Moore); there are no combinational input-to-output paths.
- Reset (asynchronous, immediate):
  - state=BOOT, bootCnt=0, waitCnt=0, haltPending=0, pcSel=0, instrCount=0.
  - All enables, o_pcWrite, o_halted and o_timeout are 0.
- State encoding: BOOT=0, IDLE=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, MEM_WAIT=6, WB=7, HALT=8, ERR=9.
- BOOT:
  - bootCnt increments each cycle.
  - At bootCnt==BOOT_CYCLES-1, go to FETCH if i_run=1, else IDLE.
- IDLE: go to FETCH when i_run=1.
- FETCH: o_enIF=1; next state DECODE unconditionally.
- DECODE: o_enID=1; haltPending <= i_halt; next state EXEC.
- EXEC: o_enEX=1; next state MEM.
- MEM: o_enMEM=1.
  - i_memReq=0, or i_memReq=1 with i_memReady=1: go to WB and latch pcSel <= i_PCSrc.
  - Otherwise: go to MEM_WAIT with waitCnt=0.
- MEM_WAIT: o_enMEM=1.
  - i_memReady=1: go to WB and latch pcSel <= i_PCSrc.
  - Else if waitCnt==MEM_WAIT_MAX-1: go to ERR.
  - Else waitCnt++.
- WB: o_enWB=1, o_pcWrite=1, o_pcSel=pcSel; instrCount++ (wraps 0xFFFFFFFF→0).
  - Next state: HALT if haltPending; else FETCH if i_run; else IDLE.
- HALT: o_halted=1; all enables 0; left only by reset.
- ERR: o_timeout=1; all enables 0; instrCount frozen; left only by reset.
- Latency:
  - Non-memory instruction: 5 cycles, FETCH to WB inclusive.
  - Memory instruction: 5 cycles plus the number of MEM_WAIT cycles.
- Exactly one stage enable is high in FETCH..WB; none are high in BOOT, IDLE, HALT or ERR.
- i_run deasserted mid-instruction: the current instruction completes through WB, then the FSM enters IDLE. i_run is ignored outside BOOT-exit, IDLE and WB.
- i_halt and i_run=0 together at WB: HALT takes priority.
- i_memReady asserted outside MEM/MEM_WAIT: ignored.

Decomposition:
- Package core_seq_pkg holds:
  - the state enum typedef (4-bit);
  - state encoding constants;
  - BOOT_CYCLES and MEM_WAIT_MAX defaults.
- One sub-module, seq_timer: loadable up-counter with a terminal-count flag.
  - One instance serves bootCnt; a second serves waitCnt.
- The FSM and instrCount live in core_sequencer.

Test Plan:
1. i_reset high for 3 cycles, then low with i_run=1 and defaults → BOOT for 4 cycles. Then o_enIF, o_enID, o_enEX, o_enMEM and o_enWB are each high for exactly one successive cycle (cycles 5–9). o_instrCount=1 after WB; FETCH is re-entered.
2. i_memReq=1, i_memReady=0 until the 3rd MEM_WAIT cycle → o_enMEM high for 4 cycles, instruction takes 8 cycles, o_instrCount increments once.
3. i_memReq=1, i_memReady held 0 → ERR after exactly 16 MEM_WAIT cycles. o_timeout=1 and o_state=9, with no further enables. o_instrCount is unchanged; i_run toggling has no effect.
4. i_halt=1 only during DECODE → the instruction completes WB (o_instrCount+1), then HALT with o_halted=1 and no o_enIF while i_run=1. Reset returns to BOOT.
5. i_memReq=0, i_PCSrc=1 in MEM → in WB, o_pcWrite=1 and o_pcSel=1. In the next instruction with i_PCSrc=0, o_pcSel=0 at its WB.
6. i_reset asserted mid-EXEC (asynchronously, between edges) → o_enEX drops immediately, o_state=0 and o_instrCount=0. Sequencing restarts after BOOT_CYCLES once reset is released.
